// File: rtl/alu_issue_ctrl_if.sv
// Command and response handshake bundle for alu_issue_ctrl.
// valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
// The sender holds valid and its payload stable until that edge.
interface alu_issue_ctrl_if #(
   parameter int REG_AW = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [REG_AW-1:0] cmd_rd;
   logic [REG_AW-1:0] cmd_rs;
   logic [REG_AW-1:0] cmd_rt;
   logic              cmd_imm_en;
   logic [15:0]       cmd_imm;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_data;
   logic [REG_AW-1:0] rsp_rd;

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_rd
   );

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_rd
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: reads operands from a small register
// file, drives the ALU, writes back the result and returns it on a response handshake.
module alu_issue_ctrl #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   alu_issue_ctrl_if.slave    bus,
   output logic [31:0]        alu_a,
   output logic [31:0]        alu_b,
   output logic [2:0]         alu_op,
   input  logic [31:0]        alu_c,
   output logic [CNT_W-1:0]   op_count,
   output logic [1:0]         o_dbg_state
);
   localparam int NREG = 2 ** REG_AW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [31:0]         r_rf [NREG];
   logic [31:0]         r_alu_a;
   logic [31:0]         r_alu_b;
   logic [2:0]          r_alu_op;
   logic [REG_AW-1:0]   r_rd;
   logic [31:0]         r_rsp_data;
   logic [REG_AW-1:0]   r_rsp_rd;
   logic [CNT_W-1:0]    r_op_count;
   logic                w_accept;
   logic                w_rsp_fire;
   logic [31:0]         w_rs_val;
   logic [31:0]         w_rt_val;
   logic [31:0]         w_b_val;

   assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid;
   assign w_rsp_fire = (r_state == S_RESP) && bus.rsp_ready;

   // Entry 0 is never written, but force zero on read so it cannot leak.
   assign w_rs_val = (bus.cmd_rs == '0) ? 32'd0 : r_rf[bus.cmd_rs];
   assign w_rt_val = (bus.cmd_rt == '0) ? 32'd0 : r_rf[bus.cmd_rt];
   assign w_b_val  = bus.cmd_imm_en ? {{16{bus.cmd_imm[15]}}, bus.cmd_imm} : w_rt_val;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (bus.cmd_valid) w_next_state = S_EXEC;
         S_EXEC:  w_next_state = S_RESP;
         S_RESP:  if (bus.rsp_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_op   <= '0;
         r_rd       <= '0;
         r_rsp_data <= '0;
         r_rsp_rd   <= '0;
         r_op_count <= '0;
         for (int i = 0; i < NREG; i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_alu_a  <= w_rs_val;
            r_alu_b  <= w_b_val;
            r_alu_op <= bus.cmd_op;
            r_rd     <= bus.cmd_rd;
         end
         if (r_state == S_EXEC) begin
            r_rsp_data <= alu_c;
            r_rsp_rd   <= r_rd;
            if (r_rd != '0) begin
               r_rf[r_rd] <= alu_c;
            end
         end
         if (w_rsp_fire) begin
            r_op_count <= r_op_count + 1'b1;
         end
      end
   end

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_rd    = r_rsp_rd;
   assign alu_a         = r_alu_a;
   assign alu_b         = r_alu_b;
   assign alu_op        = r_alu_op;
   assign op_count      = r_op_count;
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, randomized commands against
// a register-file model, backpressure and reset-abort sequences.
module tb_alu_issue_ctrl;
  logic        clk;
  logic        reset;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;
  logic [15:0] op_count;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [31:0] exp_rf[8];
  logic [31:0] exp_q[$];

  alu_issue_ctrl_if #(.REG_AW(3)) bus ();

  alu_issue_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_c       (alu_c),
    .op_count    (op_count),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // team ALU: combinational, shifts use the low 5 bits of B
  function automatic logic [31:0] team_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a >> b[4:0];
      default: return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  assign alu_c = team_alu(alu_op, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: one command, expected operands and result supplied by caller
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic ie, input logic [15:0] imm,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ed,
                        input int hold, input logic noise, input string tag);
    @(negedge clk);
    check({tag, " cmd_ready idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_rd     = rd;
    bus.cmd_rs     = rs;
    bus.cmd_rt     = rt;
    bus.cmd_imm_en = ie;
    bus.cmd_imm    = imm;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check({tag, " alu_a"}, alu_a, ea);
    check({tag, " alu_b"}, alu_b, eb);
    check({tag, " alu_op"}, 32'(alu_op), 32'(op));
    check({tag, " exec cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " rsp_data"}, bus.rsp_data, ed);
    check({tag, " rsp_rd"}, 32'(bus.rsp_rd), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (noise) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 3'($urandom_range(0, 7));
        bus.cmd_rd     = 3'($urandom_range(1, 7));
        bus.cmd_rs     = 3'($urandom_range(0, 7));
        bus.cmd_imm_en = 1'b1;
        bus.cmd_imm    = 16'($urandom);
      end
      @(posedge clk);
      #1;
      check({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, " hold rsp_data"}, bus.rsp_data, ed);
      check({tag, " hold cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      check({tag, " hold alu_a"}, alu_a, ea);
      check({tag, " hold count"}, 32'(op_count), 32'(exp_cnt[15:0]));
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    check({tag, " done rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " done cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, " op_count"}, 32'(op_count), 32'(exp_cnt[15:0]));
  endtask

  // reference model: spec-level register file semantics
  task automatic model_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic ie, input logic [15:0] imm,
                           input int hold, input string tag);
    logic [31:0] a, b, c;
    a = exp_rf[rs];
    b = ie ? 32'($signed(imm)) : exp_rf[rt];
    c = team_alu(op, a, b);
    exp_q.push_back(c);
    if (rd != 3'd0) exp_rf[rd] = c;
    do_cmd(op, rd, rs, rt, ie, imm, a, b, exp_q.pop_front(), hold, 1'b0, tag);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        ie;
    logic [15:0] imm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5,      32'd0,        32'd5,        32'd5};
    vecs[1] = '{3'd1, 3'd2, 3'd0, 3'd1, 1'b0, 16'd0,      32'd0,        32'd5,        32'hFFFFFFFB};
    vecs[2] = '{3'd0, 3'd3, 3'd0, 3'd0, 1'b1, 16'h8000,   32'd0,        32'hFFFF8000, 32'hFFFF8000};
    vecs[3] = '{3'd4, 3'd4, 3'd2, 3'd0, 1'b1, 16'd1,      32'hFFFFFFFB, 32'd1,        32'h7FFFFFFD};
    vecs[4] = '{3'd5, 3'd5, 3'd2, 3'd0, 1'b1, 16'd1,      32'hFFFFFFFB, 32'd1,        32'hFFFFFFFD};
    vecs[5] = '{3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'd7,      32'd0,        32'd7,        32'd7};
    vecs[6] = '{3'd3, 3'd6, 3'd0, 3'd0, 1'b0, 16'd0,      32'd0,        32'd0,        32'd0};

    reset          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs     = '0;
    bus.cmd_rt     = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = '0;
    bus.rsp_ready  = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst op_count", 32'(op_count), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst rsp_data", bus.rsp_data, 32'd0);
    check("rst rsp_rd", 32'(bus.rsp_rd), 32'd0);

    // directed table; keep the model register file in step
    for (int i = 0; i < 7; i++) begin
      do_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].ie, vecs[i].imm,
             vecs[i].ea, vecs[i].eb, vecs[i].ed, 0, 1'b0, $sformatf("vec%0d", i));
      if (vecs[i].rd != 3'd0) exp_rf[vecs[i].rd] = vecs[i].ed;
    end

    // backpressure: 5 held cycles with a competing command offered
    model_cmd(3'd0, 3'd7, 3'd3, 3'd0, 1'b1, 16'h0010, 0, "bp_setup");
    do_cmd(3'd2, 3'd6, 3'd7, 3'd3, 1'b0, 16'd0, exp_rf[7], exp_rf[3], exp_rf[7] & exp_rf[3],
           5, 1'b1, "bp");
    exp_rf[6] = exp_rf[7] & exp_rf[3];

    // randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      model_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // reset during EXEC aborts the write-back and response
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 3'd0;
    bus.cmd_rd     = 3'd1;
    bus.cmd_rs     = 3'd0;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 16'd9;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 32'd0;
    exp_cnt = 0;
    #1;
    check("abort rsp_valid in reset", 32'(bus.rsp_valid), 32'd0);
    check("abort op_count in reset", 32'(op_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("abort op_count", 32'(op_count), 32'd0);
      check("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
    end
    do_cmd(3'd3, 3'd7, 3'd1, 3'd0, 1'b0, 16'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0, "abort r1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
